// File: rtl/axi4_lite_regfile_pkg.sv
// Shared types for the AXI4-Lite register file.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi4_lite_regfile_pkg;

    // AXI response codes this block can return.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Zero-extended compare of a word index against the register count.
    // The extra bit keeps the check correct when the index field is exactly
    // wide enough to hold N_REGS-1.
    function automatic logic idx_out_of_range(input logic [31:0] idx, input int n_regs);
        return idx >= 32'(n_regs);
    endfunction

endpackage

// File: rtl/axi4_lite_regfile_bank.sv
// Storage array for the register file: byte-enabled write port, registered read port.
// Latency: write visible one clock after we; rdata valid one clock after re.
// Backpressure: none, accepts a write and a read every cycle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset (clears every register and rdata)
//   we/widx/wdata/wstrb  write port, byte i written where wstrb[i]=1
//   re/ridx/rdata     read port; rdata holds its value until the next re
module axi4_lite_regfile_bank #(
    parameter int N_BYTES = 4,
    parameter int N_REGS  = 16,
    parameter int IDX_W   = $clog2(N_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       widx,
    input  logic [8*N_BYTES-1:0]   wdata,
    input  logic [N_BYTES-1:0]     wstrb,
    input  logic                   re,
    input  logic [IDX_W-1:0]       ridx,
    output logic [8*N_BYTES-1:0]   rdata
);

    logic [8*N_BYTES-1:0] mem [N_REGS];

    // Read samples the array before this edge's write lands, so a read and
    // a write to the same register in one cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_REGS; r++) begin
                mem[r] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < N_BYTES; b++) begin
                    if (wstrb[b]) begin
                        mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= mem[ridx];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register bank with byte-strobe writes and readback.
// Latency: BVALID one cycle after the later of AW/W handshakes; RVALID one cycle after AR.
// Backpressure: AW/W each buffer one beat and stall while a B response is pending; AR stalls while RVALID.
//
// Optional feature macro AXIL_REGFILE_DECERR_EN:
//   defined   - out-of-range word index: writes dropped with SLVERR, reads return 0 with SLVERR
//   undefined - index wraps modulo N_REGS, all responses OKAY
//
// Ports: ACLK/ARESETn (async active-low), AXI4-Lite AW, W, B, AR, R channels.
// AWPROT/ARPROT are accepted and ignored.
module axi4_lite_regfile
    import axi4_lite_regfile_pkg::*;
#(
    parameter int N_BYTES    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int N_REGS     = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [ADDR_WIDTH-1:0]  AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [8*N_BYTES-1:0]   WDATA,
    input  logic [N_BYTES-1:0]     WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    input  logic                   BREADY,
    input  logic [ADDR_WIDTH-1:0]  ARADDR,
    input  logic [2:0]             ARPROT,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [8*N_BYTES-1:0]   RDATA,
    output logic [1:0]             RRESP,
    output logic                   RVALID,
    input  logic                   RREADY
);

    localparam int DW     = 8 * N_BYTES;
    localparam int OFFS   = $clog2(N_BYTES);
    localparam int IDX_W  = $clog2(N_REGS);
    localparam int WIDX_W = ADDR_WIDTH - OFFS;

    logic              aw_full;
    logic              w_full;
    logic [WIDX_W-1:0] aw_widx;
    logic [DW-1:0]     w_data;
    logic [N_BYTES-1:0] w_strb;
    resp_t             bresp_q;
    resp_t             rresp_q;
    logic              rd_oob;
    logic [DW-1:0]     bank_rdata;

    logic [WIDX_W-1:0] ar_widx;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic              wr_oob, ar_oob;

    assign AWREADY = !aw_full;
    assign WREADY  = !w_full;
    assign ARREADY = !RVALID;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign b_hs   = BVALID && BREADY;
    assign r_hs   = RVALID && RREADY;
    // Holding off the commit while B is outstanding is what stalls AW/W.
    assign commit = aw_full && w_full && !BVALID;

    assign ar_widx = ARADDR[ADDR_WIDTH-1:OFFS];

`ifdef AXIL_REGFILE_DECERR_EN
    assign wr_oob = idx_out_of_range(32'(aw_widx), N_REGS);
    assign ar_oob = idx_out_of_range(32'(ar_widx), N_REGS);
`else
    // Upper index bits are simply dropped by the bank, giving modulo aliasing.
    assign wr_oob = 1'b0;
    assign ar_oob = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_widx <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            BVALID  <= 1'b0;
            bresp_q <= OKAY;
            RVALID  <= 1'b0;
            rresp_q <= OKAY;
            rd_oob  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_widx <= AWADDR[ADDR_WIDTH-1:OFFS];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            // commit needs both buffers full, so it never collides with a
            // handshake into the same buffer.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                BVALID  <= 1'b1;
                bresp_q <= wr_oob ? SLVERR : OKAY;
            end else if (b_hs) begin
                BVALID <= 1'b0;
            end
            if (ar_hs) begin
                RVALID  <= 1'b1;
                rresp_q <= ar_oob ? SLVERR : OKAY;
                rd_oob  <= ar_oob;
            end else if (r_hs) begin
                RVALID <= 1'b0;
            end
        end
    end

    axi4_lite_regfile_bank #(
        .N_BYTES (N_BYTES),
        .N_REGS  (N_REGS),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .we    (commit && !wr_oob),
        .widx  (aw_widx[IDX_W-1:0]),
        .wdata (w_data),
        .wstrb (w_strb),
        .re    (ar_hs),
        .ridx  (ar_widx[IDX_W-1:0]),
        .rdata (bank_rdata)
    );

    assign BRESP = bresp_q;
    assign RRESP = rresp_q;
    assign RDATA = rd_oob ? '0 : bank_rdata;

    // Protection bits, byte-offset bits and (when aliasing) upper index bits
    // carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR, ARADDR, aw_widx, ar_widx};

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile (N_BYTES=4, ADDR_WIDTH=12, N_REGS=16).
// Directed scenarios followed by random traffic compared against an array model.
// Honours AXIL_REGFILE_DECERR_EN for out-of-range expectations.
module tb_axi4_lite_regfile;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [11:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [11:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [16];

    axi4_lite_regfile #(.N_BYTES(4), .ADDR_WIDTH(12), .N_REGS(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Reference model: word address = byte address / 4, 16 registers.
    task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        resp = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
        if (idx >= 16) begin
            resp = 2'b10;
            return;
        end
`endif
        idx = idx % 16;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic model_read(input logic [11:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        resp = 2'b00;
`ifdef AXIL_REGFILE_DECERR_EN
        if (idx >= 16) begin
            resp = 2'b10;
            data = 32'h0;
            return;
        end
`endif
        data = model[idx % 16];
    endtask

    // Write with independent AW/W start delays; BREADY is high before BVALID.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat, output int stalls);
        bit aw_done, w_done, aw_f, w_f;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; stalls = 0; lat = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; BREADY = 1'b1;
        while (!(aw_done && w_done) && cyc < 64) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            if ((AWVALID && !aw_f) || (WVALID && !w_f)) stalls++;
            step();
            aw_done |= aw_f;
            w_done  |= w_f;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check("wr_accept", {aw_done, w_done}, 2'b11);
        while (!BVALID && lat < 16) begin
            step();
            lat++;
        end
        resp = BRESP;
        step();
        check("b_done_first_cycle", BVALID, 1'b0);
        BREADY = 1'b0;
    endtask

    // Read; RREADY held low for rdy_dly cycles after RVALID to test hold.
    task automatic axi_read(input logic [11:0] addr, input int rdy_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0; n = 0;
        while (!ARREADY && n < 16) begin
            step();
            n++;
        end
        step();
        ARVALID = 1'b0;
        lat = 1;
        while (!RVALID && lat < 16) begin
            step();
            lat++;
        end
        data = RDATA; resp = RRESP;
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            check("r_hold_vld", RVALID, 1'b1);
            check("r_hold_dat", RDATA, data);
            check("r_hold_resp", RRESP, resp);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check("r_clear", RVALID, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp, exp_resp;
        logic [31:0] data, exp_data;
        logic [11:0] addr;
        logic [31:0] wvals [2];
        logic [11:0] waddrs [2];
        logic [31:0] rvals [2];
        int lat, stalls, aw_i, w_i, b_cnt, ar_i, r_cnt, cyc;
        bit aw_f, w_f, b_f, ar_f, r_f;

        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        ARESETn = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
        step(); step();
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();

        // 1. full-word write and readback
        AWPROT = 3'b010; ARPROT = 3'b101;
        axi_write(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat, stalls);
        model_write(12'h004, 32'hDEADBEEF, 4'hF, exp_resp);
        check("t1_bresp", resp, 2'b00);
        axi_read(12'h004, 0, data, resp, lat);
        check("t1_rdata", data, 32'hDEADBEEF);
        check("t1_rresp", resp, 2'b00);
        check("t1_rlat", lat, 1);

        // 2. single byte strobe, with RREADY stalled to check hold
        axi_write(12'h004, 32'h11223344, 4'b0010, 0, 0, resp, lat, stalls);
        model_write(12'h004, 32'h11223344, 4'b0010, exp_resp);
        axi_read(12'h004, 3, data, resp, lat);
        check("t2_rdata", data, 32'hDEAD33EF);
        check("t2_model", data, model[1]);

        // 3. AW before W and W before AW
        axi_write(12'h010, 32'h01020304, 4'hF, 0, 3, resp, lat, stalls);
        model_write(12'h010, 32'h01020304, 4'hF, exp_resp);
        check("t3a_stalls", stalls, 0);
        check("t3a_blat", lat, 1);
        axi_write(12'h014, 32'h0A0B0C0D, 4'hF, 3, 0, resp, lat, stalls);
        model_write(12'h014, 32'h0A0B0C0D, 4'hF, exp_resp);
        check("t3b_stalls", stalls, 0);
        check("t3b_blat", lat, 1);
        check("t3b_bresp", resp, 2'b00);

        // 4. streaming writes with VALIDs held and BREADY tied high
        waddrs[0] = 12'h008; wvals[0] = 32'hA5A5A5A5;
        waddrs[1] = 12'h00C; wvals[1] = 32'h5A5A5A5A;
        aw_i = 0; w_i = 0; b_cnt = 0; BREADY = 1'b1; WSTRB = 4'hF;
        for (int c = 0; c < 14; c++) begin
            AWVALID = aw_i < 2; WVALID = w_i < 2;
            AWADDR = waddrs[aw_i % 2]; WDATA = wvals[w_i % 2];
            aw_f = AWVALID && AWREADY; w_f = WVALID && WREADY; b_f = BVALID && BREADY;
            step();
            if (aw_f) aw_i++;
            if (w_f) w_i++;
            if (b_f) b_cnt++;
        end
        AWVALID = 0; WVALID = 0; BREADY = 0;
        check("t4_bcount", b_cnt, 2);
        model_write(12'h008, 32'hA5A5A5A5, 4'hF, exp_resp);
        model_write(12'h00C, 32'h5A5A5A5A, 4'hF, exp_resp);
        ar_i = 0; r_cnt = 0; cyc = 0; RREADY = 1'b1;
        while (r_cnt < 2 && cyc < 20) begin
            ARVALID = ar_i < 2;
            ARADDR = waddrs[ar_i % 2];
            ar_f = ARVALID && ARREADY; r_f = RVALID && RREADY;
            if (r_f) rvals[r_cnt] = RDATA;
            step();
            cyc++;
            if (ar_f) ar_i++;
            if (r_f) r_cnt++;
        end
        ARVALID = 0; RREADY = 0;
        check("t4_rcount", r_cnt, 2);
        check("t4_rcycles", cyc, 4);
        check("t4_r0", rvals[0], 32'hA5A5A5A5);
        check("t4_r1", rvals[1], 32'h5A5A5A5A);

        // 5. out-of-range index 16
        axi_write(12'h040, 32'h12345678, 4'hF, 0, 0, resp, lat, stalls);
        model_write(12'h040, 32'h12345678, 4'hF, exp_resp);
        axi_read(12'h040, 0, data, resp, lat);
        model_read(12'h040, exp_data, exp_resp);
`ifdef AXIL_REGFILE_DECERR_EN
        check("t5_rdata", data, 32'h0);
        check("t5_rresp", resp, 2'b10);
        axi_read(12'h000, 0, data, resp, lat);
        check("t5_reg0", data, 32'h0);
`else
        check("t5_rdata", data, 32'h12345678);
        check("t5_rresp", resp, 2'b00);
        axi_read(12'h000, 0, data, resp, lat);
        check("t5_reg0", data, 32'h12345678);
`endif
        check("t5_model", data, model[0]);

        // Read and commit to the same register on one edge: old value returned
        axi_write(12'h018, 32'hCAFEF00D, 4'hF, 0, 0, resp, lat, stalls);
        model_write(12'h018, 32'hCAFEF00D, 4'hF, exp_resp);
        AWADDR = 12'h018; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        step();
        AWVALID = 0; WVALID = 0;
        ARADDR = 12'h018; ARVALID = 1; RREADY = 0;
        step();
        ARVALID = 0;
        check("rw_same_rvalid", RVALID, 1'b1);
        check("rw_same_bvalid", BVALID, 1'b1);
        check("rw_same_old", RDATA, 32'hCAFEF00D);
        RREADY = 1; BREADY = 1;
        step();
        RREADY = 0; BREADY = 0;
        model_write(12'h018, 32'h0BADF00D, 4'hF, exp_resp);
        axi_read(12'h018, 0, data, resp, lat);
        check("rw_same_new", data, 32'h0BADF00D);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            addr = 12'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom;
                WSTRB = 4'($urandom_range(0, 15));
                axi_write(addr, data, WSTRB, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, stalls);
                model_write(addr, data, WSTRB, exp_resp);
                check("rnd_bresp", resp, exp_resp);
                check("rnd_blat", lat, 1);
            end else begin
                axi_read(addr, $urandom_range(0, 2), data, resp, lat);
                model_read(addr, exp_data, exp_resp);
                check("rnd_rdata", data, exp_data);
                check("rnd_rresp", resp, exp_resp);
            end
        end

        // 6. reset while a B response is pending
        AWADDR = 12'h020; WDATA = 32'h77777777; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        step();
        AWVALID = 0; WVALID = 0;
        step();
        check("t6_bvalid_before", BVALID, 1'b1);
        #2 ARESETn = 1'b0;
        #1;
        check("t6_bvalid_async", BVALID, 1'b0);
        step();
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        check("t6_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int i = 0; i < 16; i++) begin
            axi_read(12'(i * 4), 0, data, resp, lat);
            check("t6_reg_clear", data, model[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
